// File: rtl/cfg_shadow_bank_pkg.sv
// Shared parameters for cfg_shadow_bank: register map, CTL_FLAG bit indices, version constants
// and the address range of every commit group.
package cfg_shadow_bank_pkg;

   localparam logic [7:0]  ADDR_CTL_FLAG          = 8'h00;
   localparam logic [7:0]  ADDR_VERSION_NUM_MAJOR = 8'h30;
   localparam logic [7:0]  ADDR_VERSION_NUM_MINOR = 8'h31;

   localparam logic [15:0] VERSION_NUM_MAJOR      = 16'h008F;
   localparam logic [15:0] VERSION_NUM_MINOR      = 16'h0001;

   localparam int unsigned CTL_FLAG_MOD_BIT       = 0;
   localparam int unsigned CTL_FLAG_STM_BIT       = 1;
   localparam int unsigned CTL_FLAG_SILENCER_BIT  = 2;
   localparam int unsigned CTL_FLAG_PWE_BIT       = 3;
   localparam int unsigned CTL_FLAG_DEBUG_BIT     = 4;
   localparam int unsigned CTL_FLAG_SYNC_BIT      = 5;
   localparam int unsigned CTL_FLAG_FORCE_FAN_BIT = 13;

   localparam int unsigned NUM_RANGES = 6;

   typedef struct packed {
      logic [7:0] first_addr;
      logic [7:0] last_addr;
   } grp_range_t;

   // Entry k belongs to CTL_FLAG bit k (MOD, STM, SILENCER, PWE, DEBUG, SYNC).
   localparam grp_range_t GROUP_RANGES [NUM_RANGES] = '{
      '{first_addr: 8'h20, last_addr: 8'h2B},
      '{first_addr: 8'h50, last_addr: 8'h63},
      '{first_addr: 8'h40, last_addr: 8'h44},
      '{first_addr: 8'hE0, last_addr: 8'hE1},
      '{first_addr: 8'hF0, last_addr: 8'hF0},
      '{first_addr: 8'h11, last_addr: 8'h14}
   };

   typedef enum logic [1:0] {StIdle, StCopy, StDone} commit_state_e;

   function automatic logic [7:0] group_first(input int unsigned k);
      return (k < NUM_RANGES) ? GROUP_RANGES[k[2:0]].first_addr : 8'h00;
   endfunction

   function automatic logic [7:0] group_last(input int unsigned k);
      return (k < NUM_RANGES) ? GROUP_RANGES[k[2:0]].last_addr : 8'h00;
   endfunction

endpackage

// File: rtl/cfg_commit_fsm.sv
// Commit sequencer: pending-request vector, IDLE/COPY/DONE FSM, copy address and UPDATE pulses.
// With CFG_BANK_WR_PROTECT_EN defined it also flags addresses inside the group being committed.
module cfg_commit_fsm
   import cfg_shadow_bank_pkg::*;
#(
   parameter int unsigned NUM_GROUPS = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flag_we_i,
   input  logic [NUM_GROUPS-1:0] flag_bits_i,
`ifdef CFG_BANK_WR_PROTECT_EN
   input  logic [7:0]            lock_addr_i,
   output logic                  lock_hit_o,
`endif
   output logic [NUM_GROUPS-1:0] pending_o,
   output logic                  busy_o,
   output logic                  copy_en_o,
   output logic [7:0]            copy_addr_o,
   output logic [NUM_GROUPS-1:0] update_o
);

   localparam int unsigned GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

   commit_state_e         state_q, state_d;
   logic [NUM_GROUPS-1:0] pending_q, pending_d;
   logic [NUM_GROUPS-1:0] done_mask;
   logic [GW-1:0]         grp_q, grp_d;
   logic [7:0]            addr_q, addr_d;
   logic [GW-1:0]         req_grp;
   logic                  req_any;

   assign done_mask = (state_q == StDone) ? (NUM_GROUPS'(1) << grp_q) : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         pending_q <= '0;
         grp_q     <= '0;
         addr_q    <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         grp_q     <= grp_d;
         addr_d_chk: addr_q <= addr_d;
      end
   end

   // DONE hands straight to the next pending group, so back-to-back commits lose no cycle.
   always_comb begin
      pending_d = (pending_q & ~done_mask) | (flag_we_i ? flag_bits_i : '0);
      req_any   = |pending_d;
      req_grp   = '0;
      for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
         if (pending_d[i]) req_grp = GW'(i);
      end
      state_d = state_q;
      grp_d   = grp_q;
      addr_d  = addr_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (req_any) begin
               state_d = StCopy;
               grp_d   = req_grp;
               addr_d  = group_first(32'(req_grp));
            end else begin
               state_d = StIdle;
            end
         end
         StCopy: begin
            if (addr_q == group_last(32'(grp_q))) state_d = StDone;
            else addr_d = addr_q + 8'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != StIdle);
      copy_en_o   = (state_q == StCopy);
      copy_addr_o = addr_q;
      pending_o   = pending_q;
      update_o    = done_mask;
`ifdef CFG_BANK_WR_PROTECT_EN
      lock_hit_o  = busy_o && (lock_addr_i >= group_first(32'(grp_q)))
                           && (lock_addr_i <= group_last(32'(grp_q)));
`endif
   end

endmodule

// File: rtl/cfg_shadow_bank.sv
// Double-buffered configuration bank: host writes a shadow array that is committed group by group
// into an active array. Define CFG_BANK_WR_PROTECT_EN to drop writes into the committing group.
module cfg_shadow_bank
   import cfg_shadow_bank_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_GROUPS = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WE,
   input  logic [7:0]            ADDR,
   input  logic [DATA_WIDTH-1:0] DIN,
   output logic [DATA_WIDTH-1:0] DOUT,
   input  logic [7:0]            ACT_ADDR,
   output logic [DATA_WIDTH-1:0] ACT_DOUT,
   output logic [NUM_GROUPS-1:0] UPDATE,
   output logic                  BUSY,
   output logic                  FORCE_FAN,
   output logic                  WR_ERR
);

   logic [DATA_WIDTH-1:0] shadow_q [256];
   logic [DATA_WIDTH-1:0] active_q [256];
   logic [DATA_WIDTH-1:0] dout_q, dout_d, act_dout_q;
   logic [NUM_GROUPS-1:0] pending;
   logic                  copy_en;
   logic [7:0]            copy_addr;
   logic                  flag_we, is_version, wr_en;

   assign flag_we    = WE && (ADDR == ADDR_CTL_FLAG);
   assign is_version = (ADDR == ADDR_VERSION_NUM_MAJOR) || (ADDR == ADDR_VERSION_NUM_MINOR);

`ifdef CFG_BANK_WR_PROTECT_EN
   logic lock_hit, wr_err_q;

   assign wr_en  = WE && !is_version && !lock_hit;
   assign WR_ERR = wr_err_q;

   always_ff @(posedge CLK) begin
      if (RST) wr_err_q <= 1'b0;
      else if (WE && lock_hit) wr_err_q <= 1'b1;
   end
`else
   assign wr_en  = WE && !is_version;
   assign WR_ERR = 1'b0;
`endif

   cfg_commit_fsm #(
      .NUM_GROUPS (NUM_GROUPS)
   ) u_commit_fsm (
      .clk_i       (CLK),
      .rst_i       (RST),
      .flag_we_i   (flag_we),
      .flag_bits_i (DIN[NUM_GROUPS-1:0]),
`ifdef CFG_BANK_WR_PROTECT_EN
      .lock_addr_i (ADDR),
      .lock_hit_o  (lock_hit),
`endif
      .pending_o   (pending),
      .busy_o      (BUSY),
      .copy_en_o   (copy_en),
      .copy_addr_o (copy_addr),
      .update_o    (UPDATE)
   );

   // The copy samples shadow_q before this cycle's host write lands.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 256; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         if (copy_en) active_q[copy_addr] <= shadow_q[copy_addr];
         if (wr_en) shadow_q[ADDR] <= DIN;
      end
   end

   always_comb begin
      dout_d = shadow_q[ADDR];
      if (ADDR == ADDR_VERSION_NUM_MAJOR)      dout_d = DATA_WIDTH'(VERSION_NUM_MAJOR);
      else if (ADDR == ADDR_VERSION_NUM_MINOR) dout_d = DATA_WIDTH'(VERSION_NUM_MINOR);
      else if (ADDR == ADDR_CTL_FLAG)          dout_d = DATA_WIDTH'(pending);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dout_q     <= '0;
         act_dout_q <= '0;
      end else begin
         dout_q     <= dout_d;
         act_dout_q <= active_q[ACT_ADDR];
      end
   end

   assign DOUT      = dout_q;
   assign ACT_DOUT  = act_dout_q;
   assign FORCE_FAN = shadow_q[ADDR_CTL_FLAG][CTL_FLAG_FORCE_FAN_BIT];

endmodule

// File: tb/tb_cfg_shadow_bank.sv
// Self-checking bench for cfg_shadow_bank: vector table, directed commit sequences and a
// randomized run against a behavioural model. Honours CFG_BANK_WR_PROTECT_EN.
module tb_cfg_shadow_bank;

`ifdef CFG_BANK_WR_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   localparam logic [7:0] R_FIRST [6] = '{8'h20, 8'h50, 8'h40, 8'hE0, 8'hF0, 8'h11};
   localparam logic [7:0] R_LAST  [6] = '{8'h2B, 8'h63, 8'h44, 8'hE1, 8'hF0, 8'h14};

   logic        CLK = 1'b0;
   logic        RST, WE, BUSY, FORCE_FAN, WR_ERR;
   logic [7:0]  ADDR, ACT_ADDR;
   logic [15:0] DIN, DOUT, ACT_DOUT;
   logic [5:0]  UPDATE;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   cfg_shadow_bank #(
      .DATA_WIDTH (16),
      .NUM_GROUPS (6)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .WE        (WE),
      .ADDR      (ADDR),
      .DIN       (DIN),
      .DOUT      (DOUT),
      .ACT_ADDR  (ACT_ADDR),
      .ACT_DOUT  (ACT_DOUT),
      .UPDATE    (UPDATE),
      .BUSY      (BUSY),
      .FORCE_FAN (FORCE_FAN),
      .WR_ERR    (WR_ERR)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; WE = 1'b0; ADDR = 8'h30; DIN = '0; ACT_ADDR = '0;
      tick();
      RST = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      WE = 1'b1; ADDR = a; DIN = d;
      tick();
      WE = 1'b0;
   endtask

   task automatic rd_shadow(input string name, input logic [7:0] a, input logic [15:0] exp);
      WE = 1'b0; ADDR = a;
      tick();
      check(name, DOUT, exp);
   endtask

   task automatic rd_active(input string name, input logic [7:0] a, input logic [15:0] exp);
      ACT_ADDR = a;
      tick();
      check(name, ACT_DOUT, exp);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100 && BUSY; i++) tick();
      check(name, BUSY, 1'b0);
   endtask

   // Behavioural model: a commit is a job (group k, first copy cycle s) that copies word i of
   // the range in cycle s+i and reports UPDATE in cycle s+n.
   logic [15:0] m_sh [256];
   logic [15:0] m_ac [256];
   logic [5:0]  m_pend;
   logic [15:0] m_dout, m_act;
   bit          m_job, m_err;
   int          m_k, m_start, m_cyc;

   function automatic void model_reset();
      for (int i = 0; i < 256; i++) begin
         m_sh[i] = '0;
         m_ac[i] = '0;
      end
      m_pend = '0; m_dout = '0; m_act = '0;
      m_job = 1'b0; m_err = 1'b0; m_k = 0; m_start = 0; m_cyc = 0;
   endfunction

   function automatic int job_len();
      return int'(R_LAST[m_k]) - int'(R_FIRST[m_k]) + 1;
   endfunction

   function automatic logic [5:0] model_update();
      if (m_job && m_cyc == m_start + job_len()) return 6'(1 << m_k);
      return 6'h00;
   endfunction

   function automatic void model_step(input logic we, input logic [7:0] a, input logic [15:0] d,
                                      input logic [7:0] aa);
      bit done, lock;
      int idx;
      done = m_job && (m_cyc == m_start + job_len());
      lock = m_job && (a >= R_FIRST[m_k]) && (a <= R_LAST[m_k]);
      if (a == 8'h00)      m_dout = {10'b0, m_pend};
      else if (a == 8'h30) m_dout = 16'h008F;
      else if (a == 8'h31) m_dout = 16'h0001;
      else                 m_dout = m_sh[a];
      m_act = m_ac[aa];
      if (m_job && m_cyc >= m_start && m_cyc < m_start + job_len()) begin
         idx = int'(R_FIRST[m_k]) + (m_cyc - m_start);
         m_ac[idx] = m_sh[idx];
      end
      if (we && a != 8'h30 && a != 8'h31) begin
         if (PROT && lock) m_err = 1'b1;
         else m_sh[a] = d;
      end
      if (done) begin
         m_pend[m_k] = 1'b0;
         m_job = 1'b0;
      end
      if (we && a == 8'h00) m_pend = m_pend | d[5:0];
      if (!m_job && m_pend != 0) begin
         for (int i = 5; i >= 0; i--) if (m_pend[i]) m_k = i;
         m_start = m_cyc + 1;
         m_job   = 1'b1;
      end
      m_cyc++;
   endfunction

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] din;
      logic [15:0] exp_dout;
      logic        exp_ff;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'h22, 16'h00FF, 16'h00FF, 1'b0};
      vecs[1] = '{8'h30, 16'h1234, 16'h008F, 1'b0};
      vecs[2] = '{8'h31, 16'hBEEF, 16'h0001, 1'b0};
      vecs[3] = '{8'h41, 16'hA5A5, 16'hA5A5, 1'b0};
      vecs[4] = '{8'h00, 16'h2000, 16'h0000, 1'b1};
      vecs[5] = '{8'hFF, 16'hFFFF, 16'hFFFF, 1'b1};
      vecs[6] = '{8'h00, 16'h0000, 16'h0000, 1'b0};
      vecs[7] = '{8'h13, 16'h0F0F, 16'h0F0F, 1'b0};

      // Reset state
      do_reset();
      check("rst_dout", DOUT, 16'h0);
      check("rst_act_dout", ACT_DOUT, 16'h0);
      check("rst_update", UPDATE, 6'h0);
      check("rst_busy", BUSY, 1'b0);
      check("rst_wr_err", WR_ERR, 1'b0);
      check("rst_force_fan", FORCE_FAN, 1'b0);

      // Vector table: write, read back, observe FORCE_FAN and no commit activity
      for (int i = 0; i < 8; i++) begin
         wr(vecs[i].addr, vecs[i].din);
         ADDR = vecs[i].addr;
         tick();
         check($sformatf("vec%0d_dout", i), DOUT, vecs[i].exp_dout);
         check($sformatf("vec%0d_ff", i), FORCE_FAN, vecs[i].exp_ff);
         check($sformatf("vec%0d_busy", i), BUSY, 1'b0);
      end

      // Group 0 commit timing
      do_reset();
      wr(8'h22, 16'h00FF);
      rd_active("mod_act_before", 8'h22, 16'h0000);
      WE = 1'b1; ADDR = 8'h00; DIN = 16'h0001;
      tick();
      WE = 1'b0;
      for (int j = 1; j <= 14; j++) begin
         check($sformatf("mod_busy_T%0d", j), BUSY, (j <= 13));
         check($sformatf("mod_update_T%0d", j), UPDATE, (j == 13) ? 6'h01 : 6'h00);
         tick();
      end
      rd_active("mod_act_22", 8'h22, 16'h00FF);

      // STM then SILENCER, pending word between the pulses
      do_reset();
      WE = 1'b1; ADDR = 8'h00; DIN = 16'h0006;
      tick();
      WE = 1'b0;
      for (int j = 1; j <= 29; j++) begin
         check($sformatf("stm_sil_update_T%0d", j), UPDATE,
               (j == 21) ? 6'h02 : (j == 27) ? 6'h04 : 6'h00);
         check($sformatf("stm_sil_busy_T%0d", j), BUSY, (j <= 27));
         if (j == 2)  check("pending_both", DOUT, 16'h0006);
         if (j == 24) check("pending_between", DOUT, 16'h0004);
         if (j == 29) check("pending_after", DOUT, 16'h0000);
         tick();
      end

      // Version registers ignore writes; FORCE_FAN needs no commit
      do_reset();
      wr(8'h30, 16'h1234);
      rd_shadow("version_major_ro", 8'h30, 16'h008F);
      wr(8'h00, 16'h2000);
      check("force_fan_next", FORCE_FAN, 1'b1);
      for (int j = 0; j < 5; j++) begin
         check($sformatf("force_fan_no_update_%0d", j), UPDATE, 6'h00);
         check($sformatf("force_fan_no_busy_%0d", j), BUSY, 1'b0);
         tick();
      end

      // Host write to 0x41 in the same cycle SILENCER copies 0x41
      do_reset();
      wr(8'h41, 16'hAAAA);
      WE = 1'b1; ADDR = 8'h00; DIN = 16'h0004;
      tick();
      WE = 1'b0;
      tick();
      check("sil_busy_at_collision", BUSY, 1'b1);
      WE = 1'b1; ADDR = 8'h41; DIN = 16'h5555;
      tick();
      WE = 1'b0;
      check("sil_wr_err", WR_ERR, PROT);
      wait_idle("sil_idle");
      check("sil_wr_err_sticky", WR_ERR, PROT);
      rd_active("sil_act_41", 8'h41, 16'hAAAA);
      rd_shadow("sil_shadow_41", 8'h41, PROT ? 16'hAAAA : 16'h5555);

      // Reset in the middle of a MOD commit
      do_reset();
      for (int a = 8'h20; a <= 8'h2B; a++) wr(8'(a), 16'h0100 + 16'(a));
      WE = 1'b1; ADDR = 8'h00; DIN = 16'h0001;
      tick();
      WE = 1'b0;
      for (int j = 1; j < 5; j++) tick();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int j = 0; j < 16; j++) begin
         check($sformatf("abort_update_%0d", j), UPDATE, 6'h00);
         check($sformatf("abort_busy_%0d", j), BUSY, 1'b0);
         tick();
      end
      for (int a = 8'h20; a <= 8'h2B; a++) rd_active($sformatf("abort_act_%0h", a), 8'(a), 16'h0);
      rd_shadow("abort_shadow_22", 8'h22, 16'h0);

      // Randomized run against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         int unsigned sel, g;
         RST = ($urandom_range(0, 999) == 0);
         WE  = ($urandom_range(0, 3) == 0);
         DIN = 16'($urandom);
         sel = $urandom_range(0, 9);
         g   = $urandom_range(0, 5);
         if (sel == 0)      ADDR = 8'h00;
         else if (sel <= 6) ADDR = 8'($urandom_range(int'(R_FIRST[g]), int'(R_LAST[g])));
         else if (sel == 7) ADDR = 8'($urandom_range(8'h30, 8'h31));
         else               ADDR = 8'($urandom);
         g = $urandom_range(0, 5);
         ACT_ADDR = 8'($urandom_range(int'(R_FIRST[g]), int'(R_LAST[g])));
         check("rnd_dout", DOUT, m_dout);
         check("rnd_act_dout", ACT_DOUT, m_act);
         check("rnd_update", UPDATE, model_update());
         check("rnd_busy", BUSY, m_job);
         check("rnd_force_fan", FORCE_FAN, m_sh[0][13]);
         check("rnd_wr_err", WR_ERR, m_err);
         if (RST) model_reset();
         else model_step(WE, ADDR, DIN, ACT_ADDR);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
